// File: rtl/johnson_seq_ctrl.sv
// Command-driven sequencer around a WIDTH-bit Johnson counter.
// Accepts LOAD/RUN/CLEAR over valid/ready, steps the ring in either direction, and flags illegal seeds.
module johnson_seq_ctrl #(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic             cmd_dir,
    input  logic [CNT_W-1:0] cmd_steps,
    input  logic [WIDTH-1:0] cmd_seed,
    input  logic             abort,
    output logic [WIDTH-1:0] q,
    output logic             busy,
    output logic             done,
    output logic             err
);

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_RUN  = 2'b01,
        S_DONE = 2'b10
    } state_t;

    typedef enum logic [1:0] {
        OP_RUN   = 2'b00,
        OP_LOAD  = 2'b01,
        OP_CLEAR = 2'b10,
        OP_RSVD  = 2'b11
    } op_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic [CNT_W-1:0] rem_q, rem_d;
    logic             dir_q, dir_d;
    logic             err_q, err_d;

    // A legal Johnson code has at most one boundary between adjacent differing bits.
    function automatic logic is_johnson(input logic [WIDTH-1:0] v);
        int unsigned edges;
        edges = 0;
        for (int unsigned i = 0; i + 1 < WIDTH; i++) begin
            if (v[i] != v[i+1]) edges++;
        end
        return (edges <= 1);
    endfunction

    function automatic logic [WIDTH-1:0] shift_ring(input logic [WIDTH-1:0] v, input logic left);
        if (left) return {v[WIDTH-2:0], ~v[WIDTH-1]};
        else      return {~v[0], v[WIDTH-1:1]};
    endfunction

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            q_q     <= '0;
            rem_q   <= '0;
            dir_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            q_q     <= q_d;
            rem_q   <= rem_d;
            dir_q   <= dir_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        q_d     = q_q;
        rem_d   = rem_q;
        dir_d   = dir_q;
        err_d   = err_q;
        unique case (state_q)
            S_IDLE: begin
                if (cmd_valid) begin
                    state_d = S_DONE;
                    case (op_t'(cmd_op))
                        OP_RUN: begin
                            if (cmd_steps != '0) begin
                                rem_d   = cmd_steps;
                                dir_d   = cmd_dir;
                                state_d = S_RUN;
                            end
                        end
                        OP_LOAD: begin
                            if (is_johnson(cmd_seed)) begin
                                q_d = cmd_seed;
                            end else begin
                                q_d   = '0;
                                err_d = 1'b1;
                            end
                        end
                        default: begin
                            q_d   = '0;
                            err_d = 1'b0;
                        end
                    endcase
                end
            end
            S_RUN: begin
                // Abort takes priority over the shift, including on the final step.
                if (abort) begin
                    state_d = S_DONE;
                end else begin
                    q_d   = shift_ring(q_q, dir_q);
                    rem_d = rem_q - 1'b1;
                    if (rem_q == CNT_W'(1)) state_d = S_DONE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    assign q         = q_q;
    assign err       = err_q;
    assign busy      = (state_q != S_IDLE);
    assign cmd_ready = (state_q == S_IDLE);
    assign done      = (state_q == S_DONE);

endmodule

// File: tb/tb_johnson_seq_ctrl.sv
// Directed bench for johnson_seq_ctrl: hand-computed Johnson sequences, abort, illegal seeds, reset.
module tb_johnson_seq_ctrl;

    localparam int unsigned WIDTH = 4;
    localparam int unsigned CNT_W = 8;

    logic             clk = 1'b0;
    logic             rst;
    logic             cmd_valid;
    logic             cmd_ready;
    logic [1:0]       cmd_op;
    logic             cmd_dir;
    logic [CNT_W-1:0] cmd_steps;
    logic [WIDTH-1:0] cmd_seed;
    logic             abort;
    logic [WIDTH-1:0] q;
    logic             busy;
    logic             done;
    logic             err;

    int n_cmp  = 0;
    int n_fail = 0;

    johnson_seq_ctrl #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_dir(cmd_dir), .cmd_steps(cmd_steps), .cmd_seed(cmd_seed),
        .abort(abort), .q(q), .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Presents a command, waits (bounded) for cmd_ready, and returns 1 time unit after the accept edge.
    task automatic issue(input logic [1:0] op, input logic dir, input logic [CNT_W-1:0] steps,
                         input logic [WIDTH-1:0] seed);
        int n;
        cmd_op = op; cmd_dir = dir; cmd_steps = steps; cmd_seed = seed;
        cmd_valid = 1'b1;
        n = 0;
        while (!cmd_ready && n < 100) begin
            step();
            n++;
        end
        if (n >= 100) check("ready_timeout", 32'(cmd_ready), 32'd1);
        step();
        cmd_valid = 1'b0;
    endtask

    logic [WIDTH-1:0] exp_seq [0:7];
    int ready_low;
    int done_cnt;

    initial begin
        rst = 1'b0; cmd_valid = 1'b0; cmd_op = 2'b00; cmd_dir = 1'b0;
        cmd_steps = '0; cmd_seed = '0; abort = 1'b0;
        #12;
        check("rst_q", 32'(q), 32'h0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_ready", 32'(cmd_ready), 32'd1);
        rst = 1'b1;
        step();

        // LOAD 1000 then RUN right 5
        issue(2'b01, 1'b0, 8'd0, 4'b1000);
        check("load_q", 32'(q), 32'h8);
        check("load_done", 32'(done), 32'd1);
        step();
        check("load_done_end", 32'(done), 32'd0);
        check("load_ready", 32'(cmd_ready), 32'd1);

        exp_seq[0] = 4'b1100; exp_seq[1] = 4'b1110; exp_seq[2] = 4'b1111;
        exp_seq[3] = 4'b0111; exp_seq[4] = 4'b0011;
        issue(2'b00, 1'b0, 8'd5, 4'b0000);
        ready_low = (cmd_ready == 1'b0) ? 1 : 0;
        done_cnt  = int'(done);
        for (int i = 0; i < 5; i++) begin
            step();
            check($sformatf("runr5_q%0d", i + 1), 32'(q), 32'(exp_seq[i]));
            if (!cmd_ready) ready_low++;
            if (done) done_cnt++;
        end
        check("runr5_done_at_EN", 32'(done), 32'd1);
        step();
        if (!cmd_ready) ready_low++;
        if (done) done_cnt++;
        check("runr5_ready_low_cycles", 32'(ready_low), 32'd6);
        check("runr5_done_pulses", 32'(done_cnt), 32'd1);

        // CLEAR, RUN left 4, then RUN right 8 (full period)
        issue(2'b10, 1'b0, 8'd0, 4'b0000);
        check("clr_q", 32'(q), 32'h0);
        step();
        exp_seq[0] = 4'b0001; exp_seq[1] = 4'b0011; exp_seq[2] = 4'b0111; exp_seq[3] = 4'b1111;
        issue(2'b00, 1'b1, 8'd4, 4'b0000);
        for (int i = 0; i < 4; i++) begin
            step();
            check($sformatf("runl4_q%0d", i + 1), 32'(q), 32'(exp_seq[i]));
        end
        step();
        issue(2'b00, 1'b0, 8'd8, 4'b0000);
        for (int i = 0; i < 8; i++) begin
            step();
            if (i == 3) check("runr8_mid", 32'(q), 32'h0);
        end
        check("runr8_period", 32'(q), 32'hF);
        check("runr8_done", 32'(done), 32'd1);
        step();

        // Illegal seed handling, sticky err
        issue(2'b01, 1'b0, 8'd0, 4'b1011);
        check("bad_seed_q", 32'(q), 32'h0);
        check("bad_seed_err", 32'(err), 32'd1);
        step();
        issue(2'b01, 1'b0, 8'd0, 4'b1100);
        check("good_seed_q", 32'(q), 32'hC);
        check("err_sticky", 32'(err), 32'd1);
        step();
        issue(2'b11, 1'b0, 8'd0, 4'b0000);
        check("rsvd_clr_q", 32'(q), 32'h0);
        check("rsvd_clr_err", 32'(err), 32'd0);
        step();

        // Abort sampled at E4 of RUN right 10
        issue(2'b00, 1'b0, 8'd10, 4'b0000);
        step(); step(); step();
        check("abort_pre_q", 32'(q), 32'hE);
        abort = 1'b1;
        step();
        abort = 1'b0;
        check("abort_q", 32'(q), 32'hE);
        check("abort_done", 32'(done), 32'd1);
        step();
        check("abort_done_once", 32'(done), 32'd0);
        check("abort_ready", 32'(cmd_ready), 32'd1);

        // Abort coincident with final step of RUN 3
        issue(2'b10, 1'b0, 8'd0, 4'b0000);
        step();
        issue(2'b00, 1'b0, 8'd3, 4'b0000);
        step(); step();
        abort = 1'b1;
        step();
        abort = 1'b0;
        check("abort_last_q", 32'(q), 32'hC);
        check("abort_last_done", 32'(done), 32'd1);
        step();

        // RUN with zero steps
        issue(2'b01, 1'b0, 8'd0, 4'b0011);
        step();
        issue(2'b00, 1'b1, 8'd0, 4'b0000);
        check("run0_q", 32'(q), 32'h3);
        check("run0_done", 32'(done), 32'd1);
        step();
        check("run0_ready", 32'(cmd_ready), 32'd1);
        check("run0_done_end", 32'(done), 32'd0);

        // cmd_valid held during busy: LOAD must wait for cmd_ready
        issue(2'b00, 1'b0, 8'd3, 4'b0000);
        cmd_op = 2'b01; cmd_seed = 4'b1110; cmd_valid = 1'b1;
        exp_seq[0] = 4'b0001; exp_seq[1] = 4'b0000; exp_seq[2] = 4'b1000;
        for (int i = 0; i < 3; i++) begin
            step();
            check($sformatf("held_q%0d", i + 1), 32'(q), 32'(exp_seq[i]));
        end
        step();
        check("held_idle_q", 32'(q), 32'h8);
        check("held_idle_ready", 32'(cmd_ready), 32'd1);
        step();
        cmd_valid = 1'b0;
        check("held_load_q", 32'(q), 32'hE);
        step();

        // abort while IDLE is ignored
        abort = 1'b1;
        step();
        check("idle_abort_busy", 32'(busy), 32'd0);
        check("idle_abort_q", 32'(q), 32'hE);
        issue(2'b00, 1'b0, 8'd1, 4'b0000);
        abort = 1'b0;
        check("idle_abort_run", 32'(busy), 32'd1);
        step();
        check("idle_abort_shift", 32'(q), 32'hF);
        step();

        // Asynchronous reset mid-RUN
        issue(2'b01, 1'b0, 8'd0, 4'b1011);
        step();
        issue(2'b00, 1'b1, 8'd10, 4'b0000);
        step(); step();
        #2;
        rst = 1'b0;
        #1;
        check("arst_q", 32'(q), 32'h0);
        check("arst_err", 32'(err), 32'd0);
        check("arst_busy", 32'(busy), 32'd0);
        check("arst_done", 32'(done), 32'd0);
        check("arst_ready", 32'(cmd_ready), 32'd1);
        step();
        rst = 1'b1;
        step(); step();
        check("arst_stays_idle", 32'(busy), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
